// File: rtl/alu_pkg.sv
// alu_pkg: funct encodings, FSM state type and op classification for alu_seq.
`default_nettype none

package alu_pkg;

    localparam logic [5:0] ALU_SLL   = 6'h00;
    localparam logic [5:0] ALU_SRL   = 6'h02;
    localparam logic [5:0] ALU_MFHI  = 6'h10;
    localparam logic [5:0] ALU_MFLO  = 6'h12;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;
    localparam logic [5:0] ALU_ADD   = 6'h20;
    localparam logic [5:0] ALU_SUB   = 6'h22;
    localparam logic [5:0] ALU_AND   = 6'h24;
    localparam logic [5:0] ALU_OR    = 6'h25;
    localparam logic [5:0] ALU_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    function automatic logic is_long_op(input logic [5:0] funct);
        return (funct == ALU_MULTU) || (funct == ALU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative unsigned shift-add multiplier / restoring divider,
// one bit per cycle, WIDTH iterations; hi_next/lo_next hold the final result when done.
`default_nettype none

module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             active;
    logic             div_sel;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             ge;

    // hi_r/lo_r are shared: {partial product, multiplier} for MUL,
    // {partial remainder, dividend/quotient} for DIV; op is multiplicand or divisor.
    always_comb begin
        mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, op} : '0);
        rem_sh   = {hi_r, lo_r[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, op};
        ge       = (rem_sh >= {1'b0, op});
        if (div_sel) begin
            hi_next = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_next = {lo_r[WIDTH-2:0], ge};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo_r[WIDTH-1:1]};
        end
    end

    assign done = active && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active  <= 1'b0;
            div_sel <= 1'b0;
            cnt     <= '0;
            op      <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else if (start) begin
            active  <= 1'b1;
            div_sel <= is_div;
            cnt     <= '0;
            op      <= is_div ? b : a;
            hi_r    <= '0;
            lo_r    <= is_div ? a : b;
        end else if (active) begin
            hi_r <= hi_next;
            lo_r <= lo_next;
            cnt  <= cnt + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle EX-stage ALU with valid/ready input, pulsed registered
// result, HI/LO registers and iterative MULTU/DIVU.
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataOut,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    state_t           state;
    logic             accept;
    logic             long_op;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] simple_res;
    logic             simple_ovf;
    logic             slt;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign long_op  = is_long_op(Signal);

    alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && long_op),
        .is_div  (Signal == ALU_DIVU),
        .a       (dataA),
        .b       (dataB),
        .done    (md_done),
        .hi_next (md_hi),
        .lo_next (md_lo)
    );

    // SLT picks the sign from the operands when they differ, so a wrapped
    // difference never corrupts the compare.
    always_comb begin
        sum        = dataA + dataB;
        diff       = dataA - dataB;
        slt        = (dataA[MSB] ^ dataB[MSB]) ? dataA[MSB] : diff[MSB];
        simple_res = '0;
        simple_ovf = 1'b0;
        case (Signal)
            ALU_ADD: begin
                simple_res = sum;
                simple_ovf = (dataA[MSB] == dataB[MSB]) && (sum[MSB] != dataA[MSB]);
            end
            ALU_SUB: begin
                simple_res = diff;
                simple_ovf = (dataA[MSB] != dataB[MSB]) && (diff[MSB] != dataA[MSB]);
            end
            ALU_AND:  simple_res = dataA & dataB;
            ALU_OR:   simple_res = dataA | dataB;
            ALU_SLT:  simple_res = {{(WIDTH-1){1'b0}}, slt};
            ALU_SLL:  simple_res = dataA << dataB[SHW-1:0];
            ALU_SRL:  simple_res = dataA >> dataB[SHW-1:0];
            ALU_MFHI: simple_res = hi;
            ALU_MFLO: simple_res = lo;
            default:  simple_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
            dataOut   <= '0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (md_done) begin
                state     <= IDLE;
                hi        <= md_hi;
                lo        <= md_lo;
                out_valid <= 1'b1;
                dataOut   <= md_lo;
                overflow  <= 1'b0;
                zero      <= (md_lo == '0);
            end else if (accept) begin
                if (long_op) begin
                    state <= (Signal == ALU_DIVU) ? DIV : MUL;
                end else begin
                    out_valid <= 1'b1;
                    dataOut   <= simple_res;
                    overflow  <= simple_ovf;
                    zero      <= (simple_res == '0);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32) with a reference model of HI/LO.
`default_nettype none
`timescale 1ns/1ps

module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] dataA = '0;
    logic [W-1:0] dataB = '0;
    logic [5:0]   Signal = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] dataOut;
    logic         overflow;
    logic         zero;
    logic         busy;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataA     (dataA),
        .dataB     (dataB),
        .Signal    (Signal),
        .out_valid (out_valid),
        .dataOut   (dataOut),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W+1:0] exp_q[$];
    int           acc_q[$];
    int           lat_q[$];
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic ovf, output int lat);
        logic [W:0]     s;
        logic [2*W-1:0] p;
        d = '0; ovf = 1'b0; lat = 1;
        case (f)
            ALU_ADD: begin s = {a[W-1], a} + {b[W-1], b}; d = s[W-1:0]; ovf = s[W] ^ s[W-1]; end
            ALU_SUB: begin s = {a[W-1], a} - {b[W-1], b}; d = s[W-1:0]; ovf = s[W] ^ s[W-1]; end
            ALU_AND:  d = a & b;
            ALU_OR:   d = a | b;
            ALU_SLT:  d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL:  d = a << b[4:0];
            ALU_SRL:  d = a >> b[4:0];
            ALU_MFHI: d = mhi;
            ALU_MFLO: d = mlo;
            ALU_MULTU: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                mhi = p[2*W-1:W]; mlo = p[W-1:0]; d = mlo; lat = W + 1;
            end
            ALU_DIVU: begin
                if (b == '0) begin mlo = '1; mhi = a; end
                else begin mlo = a / b; mhi = a % b; end
                d = mlo; lat = W + 1;
            end
            default: d = '0;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the request is accepted.
    task automatic send(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int acc, output int waited);
        logic [W-1:0] d;
        logic         ovf;
        int           lat;
        Signal = f; dataA = a; dataB = b; in_valid = 1'b1; waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        model(f, a, b, d, ovf, lat);
        exp_q.push_back({d, ovf, (d == '0)});
        acc_q.push_back(cyc);
        lat_q.push_back(lat);
        acc = cyc;
        @(negedge clk);
    endtask

    logic [W+1:0] mon_e;
    int           mon_a;
    int           mon_l;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                mon_l = lat_q.pop_front();
                chk("data", dataOut, mon_e[W+1:2]);
                chk("ovf", overflow, mon_e[1]);
                chk("zero", zero, mon_e[0]);
                chk("latency", cyc - mon_a, mon_l);
            end
        end
    end

    initial begin
        int acc0, acc1, w0, w1, n;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dataOut", dataOut, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_zero", zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // back-to-back simple ops
        send(ALU_ADD, 32'h7FFFFFFF, 32'h1, acc0, w0);
        send(ALU_SUB, 32'd5, 32'd5, acc0, w0);
        send(ALU_SLT, 32'h80000000, 32'h7FFFFFFF, acc0, w0);
        send(ALU_SLT, 32'd3, 32'hFFFFFFFE, acc0, w0);
        send(ALU_SRL, 32'h80000000, 32'h21, acc0, w0);
        send(ALU_SLL, 32'h1, 32'd31, acc0, w0);
        send(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, acc0, w0);
        send(ALU_OR, 32'hF000_0001, 32'h0000_1000, acc0, w0);
        send(6'h3F, 32'h1234, 32'h5678, acc0, w0);
        send(ALU_ADD, 32'h80000000, 32'h80000000, acc0, w0);
        send(ALU_SUB, 32'h80000000, 32'h1, acc0, w0);
        send(ALU_SUB, 32'd3, 32'd7, acc0, w0);
        in_valid = 1'b0;
        @(negedge clk);

        // MULTU with an ADD held while busy
        send(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, acc0, w0);
        chk("busy_during_mul", busy, 1);
        chk("ready_during_mul", in_ready, 0);
        send(ALU_ADD, 32'd2, 32'd3, acc1, w1);
        chk("stall_cycles", w1, 32);
        chk("add_accept_gap", acc1 - acc0, 33);
        send(ALU_MFHI, 32'd0, 32'd0, acc0, w0);
        send(ALU_MFLO, 32'd0, 32'd0, acc0, w0);

        send(ALU_DIVU, 32'd100, 32'd7, acc0, w0);
        send(ALU_MFHI, 32'd0, 32'd0, acc0, w0);
        send(ALU_DIVU, 32'h1234, 32'd0, acc0, w0);
        send(ALU_MFHI, 32'd0, 32'd0, acc0, w0);
        send(ALU_MFLO, 32'd0, 32'd0, acc0, w0);

        for (int i = 0; i < 3; i++) begin
            send(ALU_MULTU, $urandom, $urandom, acc0, w0);
            send(ALU_MFHI, 32'd0, 32'd0, acc0, w0);
            send(ALU_DIVU, $urandom, $urandom_range(1, 5000), acc0, w0);
            send(ALU_MFHI, 32'd0, 32'd0, acc0, w0);
            send(ALU_MFLO, 32'd0, 32'd0, acc0, w0);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // reset in the middle of a DIVU
        send(ALU_DIVU, 32'd1000, 32'd3, acc0, w0);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete(); acc_q.delete(); lat_q.delete();
        mhi = '0; mlo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);
        send(ALU_MFLO, 32'd0, 32'd0, acc0, w0);
        send(ALU_MFHI, 32'd0, 32'd0, acc0, w0);
        in_valid = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
